lcd_bus_arbiter: RTL and testbench

Shares the single LCD byte-writer between two requesters: the parameter/value display FSM and a status/message source. Each requester presents a frame of LCD bytes (cursor command, then characters). The arbiter grants one requester for a whole frame so frames never interleave, and it issues each byte to the writer with the dataReady/dataDone handshake. Round-robin fairness between frames, plus a watchdog for a writer that never completes.

---
 rtl/lcd_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter.sv
// Shares the LCD byte writer between two frame sources: whole frames are granted
// round-robin, one byte in flight via dataReady/dataDone, and a watchdog abandons a stuck writer.
module lcd_bus_arbiter #(
    parameter int TIMEOUT = 4096,
    parameter int CW      = $clog2(TIMEOUT) + 1
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_rs,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_rs,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [7:0] dataIn,
    output logic       RSin,
    output logic       RWin,
    output logic       dataReady,
    input  logic       dataDone,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);
    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       rs;
        logic       last;
    } lcd_req_t;

    localparam logic [CW-1:0] WD_TERM = CW'(TIMEOUT - 1);

    lcd_req_t [1:0] req;
    lcd_req_t       sel_req;
    state_t         state, state_d;
    logic [7:0]     data_q, data_d;
    logic           rs_q, rs_d;
    logic           last_q, last_d;
    logic [1:0]     grant_q, grant_d;
    logic           rr_q, rr_d;     // 1: req1 wins the next tie
    logic [CW-1:0]  wdog_q, wdog_d;
    logic           terr_q, terr_d;
    logic           sel, xfer, wd_hit, abandon;
    logic [1:0]     ready;

    assign req[0] = {req0_valid, req0_data, req0_rs, req0_last};
    assign req[1] = {req1_valid, req1_data, req1_rs, req1_last};

    always_comb begin
        state_d = state;
        data_d  = data_q;
        rs_d    = rs_q;
        last_d  = last_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wdog_d  = wdog_q;
        terr_d  = terr_q;
        ready   = 2'b00;
        abandon = 1'b0;

        // HOLD keeps the frame owner; IDLE picks a lone requester, ties by rr_q
        sel = grant_q[1];
        if (state == IDLE)
            sel = req[1].valid && (!req[0].valid || rr_q);
        sel_req = req[sel];

        if (en && ((state == IDLE && sel_req.valid) || state == HOLD))
            ready[sel] = 1'b1;
        xfer   = ready[sel] && sel_req.valid;
        wd_hit = (wdog_q == WD_TERM);

        case (state)
            IDLE, HOLD: begin
                if (xfer) begin
                    state_d = BUSY;
                    data_d  = sel_req.data;
                    rs_d    = sel_req.rs;
                    last_d  = sel_req.last;
                    grant_d = sel ? 2'b10 : 2'b01;
                    wdog_d  = '0;
                end else if (state == HOLD) begin
                    if (wd_hit) abandon = 1'b1;
                    else        wdog_d  = wdog_q + CW'(1);
                end
            end
            BUSY: begin
                if (dataDone) begin
                    wdog_d = '0;
                    if (last_q) begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                        rr_d    = ~grant_q[1];
                    end else begin
                        state_d = HOLD;
                    end
                end else if (wd_hit) begin
                    abandon = 1'b1;
                end else begin
                    wdog_d = wdog_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (abandon) begin
            state_d = IDLE;
            grant_d = 2'b00;
            rr_d    = ~grant_q[1];
            terr_d  = 1'b1;
            wdog_d  = '0;
        end
    end

    always_ff @(posedge int_osc) begin
        if (!reset) begin
            state   <= IDLE;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            last_q  <= 1'b0;
            grant_q <= 2'b00;
            rr_q    <= 1'b0;
            wdog_q  <= '0;
            terr_q  <= 1'b0;
        end else if (en) begin
            state   <= state_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wdog_q  <= wdog_d;
            terr_q  <= terr_d;
        end
    end

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign dataIn      = data_q;
    assign RSin        = rs_q;
    assign RWin        = 1'b0;
    assign dataReady   = (state == BUSY);
    assign grant       = grant_q;
    assign busy        = |grant_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: a cycle table, hand-written corner sequences, and a
// randomized run checked against an owner/pending-byte model of the arbitration rules.
module tb_lcd_bus_arbiter;
    localparam int TO = 16;

    logic       int_osc = 1'b0;
    logic       reset, en, dataDone;
    logic       req0_valid, req0_rs, req0_last, req0_ready;
    logic       req1_valid, req1_rs, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data, dataIn;
    logic       RSin, RWin, dataReady, busy, timeout_err;
    logic [1:0] grant;

    always #5 int_osc = ~int_osc;

    lcd_bus_arbiter #(.TIMEOUT(TO)) dut (
        .int_osc(int_osc), .reset(reset), .en(en),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_rs(req0_rs),
        .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_rs(req1_rs),
        .req1_last(req1_last), .req1_ready(req1_ready),
        .dataIn(dataIn), .RSin(RSin), .RWin(RWin), .dataReady(dataReady),
        .dataDone(dataDone), .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       en, v0;
        logic [7:0] d0;
        logic       rs0, l0, v1;
        logic [7:0] d1;
        logic       rs1, l1, done;
        logic [16:0] exp;
    } vec_t;
    vec_t vq[$];

    // {r0, r1, dataReady, dataIn, RSin, RWin, grant, busy, timeout_err}
    function automatic logic [16:0] obs();
        return {req0_ready, req1_ready, dataReady, dataIn, RSin, RWin, grant, busy, timeout_err};
    endfunction

    function automatic logic [16:0] mk(input logic r0, input logic r1, input logic dr,
                                       input logic [7:0] din, input logic rs,
                                       input logic [1:0] g, input logic te);
        return {r0, r1, dr, din, rs, 1'b0, g, |g, te};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic v0, input logic [7:0] d0, input logic rs0,
                         input logic l0, input logic v1, input logic [7:0] d1, input logic rs1,
                         input logic l1, input logic dn);
        en = e; dataDone = dn;
        req0_valid = v0; req0_data = d0; req0_rs = rs0; req0_last = l0;
        req1_valid = v1; req1_data = d1; req1_rs = rs1; req1_last = l1;
    endtask

    task automatic addv(input logic e, input logic v0, input logic [7:0] d0, input logic rs0,
                        input logic l0, input logic v1, input logic [7:0] d1, input logic rs1,
                        input logic l1, input logic dn, input logic [16:0] exp);
        vec_t v;
        v.en = e; v.v0 = v0; v.d0 = d0; v.rs0 = rs0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.rs1 = rs1; v.l1 = l1; v.done = dn; v.exp = exp;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge int_osc);
        #1;
    endtask

    task automatic idle_in();
        drive(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("reset", obs(), mk(0, 0, 0, 8'h00, 0, 2'b00, 0));
    endtask

    // reference model state
    int         m_own, m_age, m_next, pick, pct;
    bit         m_wait, m_last, m_rs, m_terr, took, r0, r1;
    logic [7:0] m_din;
    logic [1:0] g;
    logic       e, v0, v1, rs0, rs1, l0, l1, dn;
    logic [7:0] d0, d1;
    int         pct_tab[3] = '{0, 20, 60};

    initial begin
        #1000000;
        $display("FAIL tb_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_in();

        // en, v0,d0,rs0,l0, v1,d1,rs1,l1, done | r0,r1,dr,din,rs,grant,terr
        addv(1, 0,8'h00,0,0, 0,8'h00,0,0, 0, mk(0,0,0,8'h00,0,2'b00,0));
        addv(1, 1,8'h80,0,0, 1,8'h32,1,1, 0, mk(1,0,0,8'h00,0,2'b00,0));
        addv(1, 1,8'h41,1,0, 1,8'h32,1,1, 0, mk(0,0,1,8'h80,0,2'b01,0));
        addv(1, 1,8'h41,1,0, 1,8'h32,1,1, 1, mk(0,0,1,8'h80,0,2'b01,0));
        addv(1, 1,8'h41,1,0, 1,8'h32,1,1, 0, mk(1,0,0,8'h80,0,2'b01,0));
        addv(1, 1,8'h42,1,1, 1,8'h32,1,1, 1, mk(0,0,1,8'h41,1,2'b01,0));
        addv(0, 1,8'h42,1,1, 1,8'h32,1,1, 0, mk(0,0,0,8'h41,1,2'b01,0));
        addv(1, 1,8'h42,1,1, 1,8'h32,1,1, 0, mk(1,0,0,8'h41,1,2'b01,0));
        addv(1, 0,8'h00,0,0, 1,8'h32,1,1, 1, mk(0,0,1,8'h42,1,2'b01,0));
        addv(1, 1,8'h55,0,1, 1,8'h32,1,1, 0, mk(0,1,0,8'h42,1,2'b00,0));
        addv(1, 1,8'h55,0,1, 0,8'h00,0,0, 0, mk(0,0,1,8'h32,1,2'b10,0));
        addv(1, 1,8'h55,0,1, 0,8'h00,0,0, 1, mk(0,0,1,8'h32,1,2'b10,0));
        addv(1, 1,8'h55,0,1, 0,8'h00,0,0, 0, mk(1,0,0,8'h32,1,2'b00,0));
        addv(1, 0,8'h00,0,0, 0,8'h00,0,0, 0, mk(0,0,1,8'h55,0,2'b01,0));

        do_reset();
        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].v0, vq[i].d0, vq[i].rs0, vq[i].l0,
                  vq[i].v1, vq[i].d1, vq[i].rs1, vq[i].l1, vq[i].done);
            #1;
            check($sformatf("vec%0d", i), obs(), vq[i].exp);
            tick();
        end

        // writer never answers a req1 byte
        do_reset();
        drive(1, 0,8'h00,0,0, 1,8'h77,0,1, 0);
        #1; check("to_ready1", req1_ready, 1);
        tick();
        idle_in();
        for (int i = 0; i < TO; i++) begin
            #1; check("to_busy", dataReady, 1);
            tick();
        end
        #1; check("to_abandon", {dataReady, grant, timeout_err}, {1'b0, 2'b00, 1'b1});
        drive(1, 1,8'h31,1,1, 0,8'h00,0,0, 0);
        #1; check("to_next_ready0", req0_ready, 1);
        tick();
        idle_in();
        #1; check("to_next_issue", {dataReady, dataIn, RSin, grant}, {1'b1, 8'h31, 1'b1, 2'b01});
        tick(); tick();
        dataDone = 1'b1; tick(); dataDone = 1'b0;
        #1; check("to_next_done", {dataReady, grant, timeout_err}, {1'b0, 2'b00, 1'b1});

        // en low mid-BUSY with an ignored dataDone; watchdog must resume from 3
        do_reset();
        drive(1, 1,8'hA5,0,1, 0,8'h00,0,0, 0);
        tick();
        idle_in();
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            dataDone = (i == 4);
            #1; check("frz_hold", {dataReady, dataIn, grant, timeout_err}, {1'b1, 8'hA5, 2'b01, 1'b0});
            tick();
        end
        dataDone = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1; check("frz_resume", dataReady, 1);
            tick();
        end
        dataDone = 1'b1;
        #1; check("frz_term", dataReady, 1);
        tick();
        dataDone = 1'b0;
        #1; check("frz_done_wins", {dataReady, grant, timeout_err}, {1'b0, 2'b00, 1'b0});

        // reset in HOLD after req0 was served last; the next tie must still go to req0
        do_reset();
        drive(1, 1,8'h11,1,1, 0,8'h00,0,0, 0);
        tick();
        idle_in(); dataDone = 1'b1; tick(); dataDone = 1'b0;
        drive(1, 1,8'h80,0,0, 0,8'h00,0,0, 0);
        #1; check("rst_ready0", req0_ready, 1);
        tick();
        drive(1, 0,8'h00,0,0, 1,8'h22,1,1, 1);
        tick();
        dataDone = 1'b0;
        #1; check("rst_hold", {req1_ready, dataReady, grant}, {1'b0, 1'b0, 2'b01});
        idle_in();
        reset = 1'b0; tick(); reset = 1'b1;
        #1; check("rst_mid_hold", obs(), mk(0, 0, 0, 8'h00, 0, 2'b00, 0));
        drive(1, 1,8'h31,1,1, 1,8'h32,1,1, 0);
        #1; check("rst_tie", {req0_ready, req1_ready}, 2'b10);
        tick();
        idle_in();
        #1; check("rst_tie_issue", {dataIn, grant}, {8'h31, 2'b01});

        // randomized run against the model
        do_reset();
        m_own = -1; m_wait = 0; m_last = 0; m_age = 0; m_next = 0;
        m_din = 8'h00; m_rs = 0; m_terr = 0; pct = 20;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) pct = pct_tab[$urandom_range(0, 2)];
            e   = ($urandom_range(0, 9) != 0);
            v0  = ($urandom_range(0, 9) < 6);
            v1  = ($urandom_range(0, 9) < 6);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            rs0 = 1'($urandom);
            rs1 = 1'($urandom);
            l0  = ($urandom_range(0, 2) == 0);
            l1  = ($urandom_range(0, 2) == 0);
            dn  = ($urandom_range(0, 99) < pct);
            drive(e, v0, d0, rs0, l0, v1, d1, rs1, l1, dn);

            pick = -1;
            if (m_own < 0) begin
                if (v0 && v1) pick = m_next;
                else if (v0)  pick = 0;
                else if (v1)  pick = 1;
            end else if (!m_wait) begin
                pick = m_own;
            end
            r0 = e && (pick == 0);
            r1 = e && (pick == 1);
            g  = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
            #1; check("rand", obs(), mk(r0, r1, m_wait, m_din, m_rs, g, m_terr));
            tick();

            if (e) begin
                took = (pick == 0 && v0) || (pick == 1 && v1);
                if (m_wait && dn) begin
                    m_wait = 0; m_age = 0;
                    if (m_last) begin m_next = 1 - m_own; m_own = -1; end
                end else if (took) begin
                    m_own  = pick; m_wait = 1; m_age = 0;
                    m_din  = (pick == 1) ? d1 : d0;
                    m_rs   = (pick == 1) ? rs1 : rs0;
                    m_last = (pick == 1) ? l1 : l0;
                end else if (m_own >= 0) begin
                    if (m_age == TO - 1) begin
                        m_terr = 1; m_next = 1 - m_own; m_own = -1; m_wait = 0; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
